// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes control, captures operands, forwards from
// EX/MEM and MEM/WB into the ALU inputs, and detects load-use hazards.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          exm_regwrite,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_result,
  input  logic          mwb_regwrite,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_result,
  output logic          stall,
  output logic [5:0]    alu_sel,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_wreg,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          ex_branch
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] SEL_ADD  = 6'b100000;
  localparam logic [5:0] SEL_SUB  = 6'b100010;

  typedef struct packed {
    logic [5:0]    sel;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
    logic          branch;
    logic          alusrc;
    logic [RW-1:0] wreg;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
  } ex_reg_t;

  ex_reg_t dec;
  ex_reg_t ex_q;
  logic    dec_valid;
  logic    uses_rt;

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    dec       = '0;
    dec_valid = 1'b0;
    unique case (id_opcode)
      OP_RTYPE: begin
        if (id_funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
          dec_valid    = 1'b1;
          dec.sel      = id_funct;
          dec.regwrite = 1'b1;
          dec.wreg     = id_rd;
        end
      end
      OP_LW: begin
        dec_valid    = 1'b1;
        dec.sel      = SEL_ADD;
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
        dec.wreg     = id_rt;
      end
      OP_SW: begin
        dec_valid    = 1'b1;
        dec.sel      = SEL_ADD;
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
      end
      OP_BEQ: begin
        dec_valid  = 1'b1;
        dec.sel    = SEL_SUB;
        dec.branch = 1'b1;
      end
      OP_ADDI: begin
        dec_valid    = 1'b1;
        dec.sel      = SEL_ADD;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.wreg     = id_rt;
      end
      default: dec_valid = 1'b0;
    endcase
    // Invalid encodings stay an all-zero bubble, including the data fields.
    if (dec_valid) begin
      dec.rs      = id_rs;
      dec.rt      = id_rt;
      dec.rs_data = id_rs_data;
      dec.rt_data = id_rt_data;
      dec.imm     = id_imm;
    end
  end

  always_comb begin
    uses_rt = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW) || (id_opcode == OP_BEQ);
    stall   = ex_q.memread && (ex_q.wreg != '0) &&
              ((ex_q.wreg == id_rs) || ((ex_q.wreg == id_rt) && uses_rt));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst || flush || stall) ex_q <= '0;
    else                       ex_q <= dec;
  end

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  // EX/MEM is the younger producer, so it wins over MEM/WB; $0 is never forwarded.
  always_comb begin
    if (exm_regwrite && (exm_rd != '0) && (exm_rd == ex_q.rs))      fwd_rs = exm_result;
    else if (mwb_regwrite && (mwb_rd != '0) && (mwb_rd == ex_q.rs)) fwd_rs = mwb_result;
    else                                                            fwd_rs = ex_q.rs_data;

    if (exm_regwrite && (exm_rd != '0) && (exm_rd == ex_q.rt))      fwd_rt = exm_result;
    else if (mwb_regwrite && (mwb_rd != '0) && (mwb_rd == ex_q.rt)) fwd_rt = mwb_result;
    else                                                            fwd_rt = ex_q.rt_data;
  end

  assign alu_sel       = ex_q.sel;
  assign alu_a         = fwd_rs;
  assign alu_b         = ex_q.alusrc ? ex_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_wreg       = ex_q.wreg;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_memtoreg   = ex_q.memtoreg;
  assign ex_branch     = ex_q.branch;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline; sits directly upstream of the ALU and drives its `sel`, `a` and `b` inputs.
- Decodes the opcode into EX/MEM/WB control bits and maps the opcode/funct to the ALU's 6-bit select.
- Registers the decode-stage operands and applies EX/MEM and MEM/WB forwarding on the operands it presents.
- Detects load-use hazards and inserts bubbles on stall or branch flush.

Parameters:
- DW, 32, datapath width
- RW, 5, register-address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  branch taken; squash the instruction entering EX
- id_opcode  in  6  instr[31:26]
- id_funct  in  6  instr[5:0]
- id_rs  in  RW  instr[25:21]
- id_rt  in  RW  instr[20:16]
- id_rd  in  RW  instr[15:11]
- id_rs_data  in  DW  register-file read port 1
- id_rt_data  in  DW  register-file read port 2
- id_imm  in  DW  sign-extended immediate
- exm_regwrite  in  1  EX/MEM writes a register
- exm_rd  in  RW  EX/MEM destination
- exm_result  in  DW  EX/MEM ALU result
- mwb_regwrite  in  1  MEM/WB writes a register
- mwb_rd  in  RW  MEM/WB destination
- mwb_result  in  DW  MEM/WB write-back value
- stall  out  1  load-use hazard; IF/ID and PC must hold
- alu_sel  out  6  ALU select (registered)
- alu_a  out  DW  forwarded rs operand
- alu_b  out  DW  forwarded rt operand, or immediate
- ex_store_data  out  DW  forwarded rt value for sw
- ex_wreg  out  RW  destination register
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch  out  1 each  registered controls

Behaviour:
- Decode (combinational, captured at the clock edge):
  - R-type (000000), funct in {100000, 100010, 100100, 100101, 101010}: sel=funct, regwrite=1, wreg=rd, alusrc=0.
  - R-type with any other funct (including 000000 / nop): bubble.
  - lw (100011): sel=100000, alusrc=1, memread=1, memtoreg=1, regwrite=1, wreg=rt.
  - sw (101011): sel=100000, alusrc=1, memwrite=1, wreg=0.
  - beq (000100): sel=100010, branch=1, alusrc=0.
  - addi (001000): sel=100000, alusrc=1, regwrite=1, wreg=rt.
  - j (000010) and any unknown opcode: bubble.
- Bubble: sel=000000 (ALU outputs 0), all control bits 0, wreg=0. Captured data fields (rs/rt data, imm, rs/rt addresses) are also 0.
- Register update priority at the rising edge: rst > flush > stall > normal load.
  - rst, flush or stall: the register loads a bubble.
  - Normal: the register loads the decoded instruction.
- Reset: every registered field is 0, so all outputs are 0 after reset. stall is 0 while the registered memread is 0.
- Stall (combinational, from registered state plus ID inputs):
  - stall = ex_memread & (ex_wreg != 0) & ((ex_wreg == id_rs) | (ex_wreg == id_rt & uses_rt)).
  - uses_rt = 1 for R-type, sw and beq.
  - A stall lasts exactly one cycle per load: the load leaves EX and the bubble enters.
  - stall and flush together: flush wins, and the bubble is inserted either way.
- Forwarding (combinational on registered rs/rt):
  - Source A = EX/MEM if exm_regwrite & exm_rd != 0 & exm_rd == ex_rs.
  - Otherwise MEM/WB if mwb_regwrite & mwb_rd != 0 & mwb_rd == ex_rs.
  - Otherwise registered rs data.
  - EX/MEM has priority over MEM/WB. The same rule applies to rt.
  - Register 0 is never forwarded.
- Operand outputs: alu_a = fwd_rs; alu_b = alusrc ? imm : fwd_rt; ex_store_data = fwd_rt.
- Latency: one cycle from ID inputs to registered outputs. Forwarded values respond in the same cycle as their inputs.
- The register file performs write-before-read; this block does not bypass into ID.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> all outputs 0 and stall=0. After release, add $3,$1,$2 (rs=1, rt=2, rd=3, data 5/7) -> next cycle alu_sel=100000, alu_a=5, alu_b=7, ex_wreg=3, ex_regwrite=1.
- Decode sweep: sub/and/or/slt -> alu_sel 100010/100100/100101/101010. lw and addi -> alu_sel 100000, alu_b=imm, wreg=rt. beq -> alu_sel 100010, ex_branch=1. funct 000011 and opcode 000010 -> alu_sel 0, all controls 0.
- Forwarding: registered rs=4 with exm_rd=4/exm_result=0x11 and mwb_rd=4/mwb_result=0x22 -> alu_a=0x11. Clear exm_regwrite -> alu_a=0x22. Set exm_rd=0 with exm_regwrite=1 -> no forward from EX/MEM. For sw with rt match -> ex_store_data forwarded while alu_b=imm.
- Load-use: lw $5 in EX, ID add rs=5 -> stall=1 for exactly one cycle, next cycle all outputs bubble. Then the add enters and forwards mwb_result into alu_a. Same case with ID addi rt=5 (rt unused) -> stall=0.
- Flush: flush=1 while a valid add is decoded -> next cycle bubble. flush=1 together with stall=1 -> a single bubble and no double stall.
- Reset mid-stream: rst asserted while lw is in EX and stall=1 -> next cycle all outputs 0 and stall=0.
